id_ex_stage: RTL and testbench

- ID/EX pipeline register plus EX-stage operand forwarding and load-use hazard detection for the 5-stage MIPS pipeline.
- Captures decoded fields from ID each cycle and resolves RAW hazards from MEM and WB.
- Drives the ALU's ALUCtrl, Sign, In1 and In2 inputs directly.
- Produces LoadUseStall for the IF/ID stage and the PC.

---
 rtl/id_ex_stage_pkg.sv | 55 +++++
 rtl/id_ex_stage_forward_unit.sv | 31 +++
 rtl/id_ex_stage.sv | 167 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU opcodes, destination-select
// encodings, the link register, and the bubble control word.
package id_ex_stage_pkg;

    // ALU opcodes; AND doubles as the all-zero bubble opcode.
    typedef enum logic [4:0] {
        ALU_AND = 5'd0,
        ALU_OR  = 5'd1,
        ALU_ADD = 5'd2,
        ALU_SUB = 5'd3,
        ALU_SLT = 5'd4,
        ALU_NOR = 5'd5,
        ALU_XOR = 5'd6,
        ALU_SLL = 5'd7,
        ALU_SRL = 5'd8,
        ALU_SRA = 5'd9
    } alu_op_e;

    // Destination-register select; code 3 is unused and maps to r0.
    typedef enum logic [1:0] {
        REGDST_RT = 2'd0,
        REGDST_RD = 2'd1,
        REGDST_RA = 2'd2
    } reg_dst_e;

    localparam logic [4:0] REG_RA = 5'd31;

    // Control word carried from ID into EX.
    typedef struct packed {
        logic [4:0] alu_ctrl;
        logic       sign;
        logic       alu_src1;
        logic       alu_src2;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
    } ctrl_t;

    // A bubble is a nop: no writes, no memory access, opcode 00000.
    localparam ctrl_t BUBBLE_CTRL = '0;

    // Picks the destination register at capture time.
    function automatic logic [4:0] sel_write_addr(input logic [1:0] reg_dst,
                                                  input logic [4:0] rt,
                                                  input logic [4:0] rd);
        case (reg_dst)
            REGDST_RT: return rt;
            REGDST_RD: return rd;
            REGDST_RA: return REG_RA;
            default:   return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Operand bypass for one source register: the youngest in-flight writer
// (MEM before WB) supplies the value; r0 is never bypassed.
module forward_unit #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] src_addr_i,
    input  logic [DW-1:0] src_data_i,
    input  logic          mem_reg_write_i,
    input  logic [AW-1:0] mem_write_addr_i,
    input  logic [DW-1:0] mem_alu_result_i,
    input  logic          wb_reg_write_i,
    input  logic [AW-1:0] wb_write_addr_i,
    input  logic [DW-1:0] wb_write_data_i,
    output logic [DW-1:0] fwd_data_o
);

    logic src_nonzero;
    assign src_nonzero = (src_addr_i != '0);

    // Priority bypass select: MEM, then WB, then register-file data.
    always_comb begin
        // NOTE: every path assigns fwd_data_o, so no latch is inferred.
        fwd_data_o = src_data_i;
        if (mem_reg_write_i && src_nonzero && (mem_write_addr_i == src_addr_i))
            fwd_data_o = mem_alu_result_i;
        else if (wb_reg_write_i && src_nonzero && (wb_write_addr_i == src_addr_i))
            fwd_data_o = wb_write_data_i;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding and load-use
// hazard detection for the 5-stage MIPS pipeline.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   ID_Instr,
    input  logic [DW-1:0] ID_RsData,
    input  logic [DW-1:0] ID_RtData,
    input  logic [DW-1:0] ID_Imm32,
    input  logic [31:0]   ID_PCPlus4,
    input  logic [4:0]    ID_ALUCtrl,
    input  logic          ID_Sign,
    input  logic          ID_ALUSrc1,
    input  logic          ID_ALUSrc2,
    input  logic [1:0]    ID_RegDst,
    input  logic          ID_RegWrite,
    input  logic          ID_MemRead,
    input  logic          ID_MemWrite,
    input  logic          ID_MemToReg,
    input  logic          Flush,
    input  logic          MEM_RegWrite,
    input  logic [AW-1:0] MEM_WriteAddr,
    input  logic [DW-1:0] MEM_ALUResult,
    input  logic          WB_RegWrite,
    input  logic [AW-1:0] WB_WriteAddr,
    input  logic [DW-1:0] WB_WriteData,
    output logic [4:0]    EX_ALUCtrl,
    output logic          EX_Sign,
    output logic [DW-1:0] EX_In1,
    output logic [DW-1:0] EX_In2,
    output logic [DW-1:0] EX_StoreData,
    output logic [AW-1:0] EX_WriteAddr,
    output logic          EX_RegWrite,
    output logic          EX_MemRead,
    output logic          EX_MemWrite,
    output logic          EX_MemToReg,
    output logic [31:0]   EX_PCPlus4,
    output logic          LoadUseStall
);

    // Instruction fields in ID.
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [4:0]    id_shamt;
    logic          unused_funct;
    assign id_rs        = AW'(ID_Instr[25:21]);
    assign id_rt        = AW'(ID_Instr[20:16]);
    assign id_rd        = AW'(ID_Instr[15:11]);
    assign id_shamt     = ID_Instr[10:6];
    assign unused_funct = ^ID_Instr[5:0];

    // Pipeline register state.
    ctrl_t         ctrl_q, ctrl_d;
    logic [AW-1:0] rs_addr_q, rs_addr_d;
    logic [AW-1:0] rt_addr_q, rt_addr_d;
    logic [AW-1:0] write_addr_q, write_addr_d;
    logic [4:0]    shamt_q, shamt_d;
    logic [DW-1:0] rs_data_q, rs_data_d;
    logic [DW-1:0] rt_data_q, rt_data_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [31:0]   pc_plus4_q, pc_plus4_d;

    // A load in EX whose target is read by the ID instruction must wait one cycle.
    assign LoadUseStall = ctrl_q.mem_read && (write_addr_q != '0) &&
                          ((write_addr_q == id_rs) || (write_addr_q == id_rt));

    // Next state: capture ID, or insert a bubble on flush/stall.
    always_comb begin
        ctrl_d       = BUBBLE_CTRL;
        rs_addr_d    = '0;
        rt_addr_d    = '0;
        write_addr_d = '0;
        shamt_d      = '0;
        rs_data_d    = '0;
        rt_data_d    = '0;
        imm_d        = '0;
        pc_plus4_d   = '0;
        if (!(Flush || LoadUseStall)) begin
            ctrl_d.alu_ctrl   = ID_ALUCtrl;
            ctrl_d.sign       = ID_Sign;
            ctrl_d.alu_src1   = ID_ALUSrc1;
            ctrl_d.alu_src2   = ID_ALUSrc2;
            ctrl_d.reg_write  = ID_RegWrite;
            ctrl_d.mem_read   = ID_MemRead;
            ctrl_d.mem_write  = ID_MemWrite;
            ctrl_d.mem_to_reg = ID_MemToReg;
            rs_addr_d         = id_rs;
            rt_addr_d         = id_rt;
            write_addr_d      = AW'(sel_write_addr(ID_RegDst, ID_Instr[20:16], ID_Instr[15:11]));
            shamt_d           = id_shamt;
            rs_data_d         = ID_RsData;
            rt_data_d         = ID_RtData;
            imm_d             = ID_Imm32;
            pc_plus4_d        = ID_PCPlus4;
        end
    end

    // ID/EX register with synchronous active-high clear.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all state updating from pre-edge values.
        if (reset) begin
            ctrl_q       <= BUBBLE_CTRL;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            write_addr_q <= '0;
            shamt_q      <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            pc_plus4_q   <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            rs_addr_q    <= rs_addr_d;
            rt_addr_q    <= rt_addr_d;
            write_addr_q <= write_addr_d;
            shamt_q      <= shamt_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    logic [DW-1:0] fwd_rs, fwd_rt;

    forward_unit #(.DW(DW), .AW(AW)) u_fwd_rs (
        .src_addr_i       (rs_addr_q),
        .src_data_i       (rs_data_q),
        .mem_reg_write_i  (MEM_RegWrite),
        .mem_write_addr_i (MEM_WriteAddr),
        .mem_alu_result_i (MEM_ALUResult),
        .wb_reg_write_i   (WB_RegWrite),
        .wb_write_addr_i  (WB_WriteAddr),
        .wb_write_data_i  (WB_WriteData),
        .fwd_data_o       (fwd_rs)
    );

    forward_unit #(.DW(DW), .AW(AW)) u_fwd_rt (
        .src_addr_i       (rt_addr_q),
        .src_data_i       (rt_data_q),
        .mem_reg_write_i  (MEM_RegWrite),
        .mem_write_addr_i (MEM_WriteAddr),
        .mem_alu_result_i (MEM_ALUResult),
        .wb_reg_write_i   (WB_RegWrite),
        .wb_write_addr_i  (WB_WriteAddr),
        .wb_write_data_i  (WB_WriteData),
        .fwd_data_o       (fwd_rt)
    );

    // The ALU reads the shift amount from In1[10:6].
    assign EX_In1       = ctrl_q.alu_src1 ? DW'({shamt_q, 6'b0}) : fwd_rs;
    assign EX_In2       = ctrl_q.alu_src2 ? imm_q : fwd_rt;
    assign EX_StoreData = fwd_rt;
    assign EX_ALUCtrl   = ctrl_q.alu_ctrl;
    assign EX_Sign      = ctrl_q.sign;
    assign EX_WriteAddr = write_addr_q;
    assign EX_RegWrite  = ctrl_q.reg_write;
    assign EX_MemRead   = ctrl_q.mem_read;
    assign EX_MemWrite  = ctrl_q.mem_write;
    assign EX_MemToReg  = ctrl_q.mem_to_reg;
    assign EX_PCPlus4   = pc_plus4_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding, load-use stall, shift
// operand, flush and reset behaviour.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ID_Instr, ID_RsData, ID_RtData, ID_Imm32, ID_PCPlus4;
    logic [4:0]  ID_ALUCtrl;
    logic        ID_Sign, ID_ALUSrc1, ID_ALUSrc2;
    logic [1:0]  ID_RegDst;
    logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg;
    logic        Flush;
    logic        MEM_RegWrite;
    logic [4:0]  MEM_WriteAddr;
    logic [31:0] MEM_ALUResult;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteAddr;
    logic [31:0] WB_WriteData;
    logic [4:0]  EX_ALUCtrl;
    logic        EX_Sign;
    logic [31:0] EX_In1, EX_In2, EX_StoreData, EX_PCPlus4;
    logic [4:0]  EX_WriteAddr;
    logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg;
    logic        LoadUseStall;

    int total = 0;
    int bad   = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .ID_Instr(ID_Instr), .ID_RsData(ID_RsData), .ID_RtData(ID_RtData),
        .ID_Imm32(ID_Imm32), .ID_PCPlus4(ID_PCPlus4), .ID_ALUCtrl(ID_ALUCtrl),
        .ID_Sign(ID_Sign), .ID_ALUSrc1(ID_ALUSrc1), .ID_ALUSrc2(ID_ALUSrc2),
        .ID_RegDst(ID_RegDst), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .ID_MemWrite(ID_MemWrite), .ID_MemToReg(ID_MemToReg), .Flush(Flush),
        .MEM_RegWrite(MEM_RegWrite), .MEM_WriteAddr(MEM_WriteAddr),
        .MEM_ALUResult(MEM_ALUResult), .WB_RegWrite(WB_RegWrite),
        .WB_WriteAddr(WB_WriteAddr), .WB_WriteData(WB_WriteData),
        .EX_ALUCtrl(EX_ALUCtrl), .EX_Sign(EX_Sign), .EX_In1(EX_In1), .EX_In2(EX_In2),
        .EX_StoreData(EX_StoreData), .EX_WriteAddr(EX_WriteAddr),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_MemToReg(EX_MemToReg), .EX_PCPlus4(EX_PCPlus4), .LoadUseStall(LoadUseStall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, sh);
        return {6'd0, rs, rt, rd, sh, 6'd0};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic drive_id(input logic [31:0] instr, rs_data, rt_data, imm,
                            input logic [4:0] alu, input logic src1, src2,
                            input logic [1:0] dst, input logic rw, mr, mw, m2r);
        ID_Instr    = instr;
        ID_RsData   = rs_data;
        ID_RtData   = rt_data;
        ID_Imm32    = imm;
        ID_ALUCtrl  = alu;
        ID_Sign     = 1'b0;
        ID_ALUSrc1  = src1;
        ID_ALUSrc2  = src2;
        ID_RegDst   = dst;
        ID_RegWrite = rw;
        ID_MemRead  = mr;
        ID_MemWrite = mw;
        ID_MemToReg = m2r;
    endtask

    task automatic clear_fwd();
        MEM_RegWrite  = 1'b0;
        MEM_WriteAddr = 5'd0;
        MEM_ALUResult = 32'd0;
        WB_RegWrite   = 1'b0;
        WB_WriteAddr  = 5'd0;
        WB_WriteData  = 32'd0;
    endtask

    task automatic drive_lw8();
        // lw $8, 4($2)
        drive_id(i_type(6'h23, 5'd2, 5'd8, 16'h0004), 32'h100, 32'h0, 32'h4,
                 ALU_ADD, 1'b0, 1'b1, REGDST_RT, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        Flush = 1'b0;
        ID_PCPlus4 = 32'h0;
        drive_id(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_fwd();
        tick();
        tick();
        check("rst_regwrite", EX_RegWrite, 0);
        check("rst_in1", EX_In1, 0);
        check("rst_stall", LoadUseStall, 0);
        reset = 1'b0;

        // add $1,$2,$3
        drive_id(r_type(5'd2, 5'd3, 5'd1, 5'd0), 32'h2, 32'h3, 32'h0,
                 ALU_ADD, 1'b0, 1'b0, REGDST_RD, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("add_waddr", EX_WriteAddr, 1);
        check("add_in1", EX_In1, 32'h2);
        check("add_in2", EX_In2, 32'h3);

        // sub $4,$1,$5 with stale rs; r1 comes from MEM
        drive_id(r_type(5'd1, 5'd5, 5'd4, 5'd0), 32'h0, 32'h5, 32'h0,
                 ALU_SUB, 1'b0, 1'b0, REGDST_RD, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        MEM_RegWrite = 1'b1; MEM_WriteAddr = 5'd1; MEM_ALUResult = 32'h10;
        #1;
        check("fwd_mem_in1", EX_In1, 32'h10);
        check("fwd_mem_in2", EX_In2, 32'h5);
        check("sub_alu", EX_ALUCtrl, ALU_SUB);
        check("sub_waddr", EX_WriteAddr, 4);
        clear_fwd();

        // add $10,$7,$7: MEM and WB both write r7
        drive_id(r_type(5'd7, 5'd7, 5'd10, 5'd0), 32'h1234, 32'h1111, 32'h0,
                 ALU_ADD, 1'b0, 1'b0, REGDST_RD, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        MEM_RegWrite = 1'b1; MEM_WriteAddr = 5'd7; MEM_ALUResult = 32'hAAAA0000;
        WB_RegWrite  = 1'b1; WB_WriteAddr  = 5'd7; WB_WriteData  = 32'h5555FFFF;
        #1;
        check("prio_in1", EX_In1, 32'hAAAA0000);
        check("prio_store", EX_StoreData, 32'hAAAA0000);
        MEM_RegWrite = 1'b0;
        #1;
        check("wb_in1", EX_In1, 32'h5555FFFF);
        check("wb_in2", EX_In2, 32'h5555FFFF);
        WB_RegWrite = 1'b0;
        #1;
        check("nofwd_in1", EX_In1, 32'h1234);
        check("nofwd_in2", EX_In2, 32'h1111);

        // add $11,$0,$0: writers targeting r0 are ignored
        drive_id(r_type(5'd0, 5'd0, 5'd11, 5'd0), 32'h0, 32'h0, 32'h0,
                 ALU_ADD, 1'b0, 1'b0, REGDST_RD, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        MEM_RegWrite = 1'b1; MEM_WriteAddr = 5'd0; MEM_ALUResult = 32'hDEAD0001;
        WB_RegWrite  = 1'b1; WB_WriteAddr  = 5'd0; WB_WriteData  = 32'hBEEF0002;
        #1;
        check("r0_in1", EX_In1, 32'h0);
        check("r0_store", EX_StoreData, 32'h0);
        clear_fwd();

        // Load-use: lw $8 then add $9,$8,$8
        drive_lw8();
        tick();
        check("lw_memread", EX_MemRead, 1);
        check("lw_waddr", EX_WriteAddr, 8);
        check("lw_in2", EX_In2, 32'h4);
        drive_id(r_type(5'd8, 5'd8, 5'd9, 5'd0), 32'h0, 32'h0, 32'h0,
                 ALU_ADD, 1'b0, 1'b0, REGDST_RD, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("lu_stall", LoadUseStall, 1);
        tick();
        check("bub_regwrite", EX_RegWrite, 0);
        check("bub_memwrite", EX_MemWrite, 0);
        check("bub_memread", EX_MemRead, 0);
        check("bub_alu", EX_ALUCtrl, 0);
        check("bub_stall", LoadUseStall, 0);
        MEM_RegWrite = 1'b1; MEM_WriteAddr = 5'd8; MEM_ALUResult = 32'h104;
        tick();
        clear_fwd();
        WB_RegWrite = 1'b1; WB_WriteAddr = 5'd8; WB_WriteData = 32'hCAFEF00D;
        #1;
        check("lu_in1", EX_In1, 32'hCAFEF00D);
        check("lu_in2", EX_In2, 32'hCAFEF00D);
        check("lu_waddr", EX_WriteAddr, 9);
        check("lu_regwrite", EX_RegWrite, 1);
        clear_fwd();

        // sll $2,$3,5 with r3 from WB
        drive_id(r_type(5'd0, 5'd3, 5'd2, 5'd5), 32'h0, 32'h7, 32'h0,
                 ALU_SLL, 1'b1, 1'b0, REGDST_RD, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        WB_RegWrite = 1'b1; WB_WriteAddr = 5'd3; WB_WriteData = 32'hF;
        #1;
        check("sll_in1", EX_In1, 32'h140);
        check("sll_in2", EX_In2, 32'hF);
        check("sll_alu", EX_ALUCtrl, ALU_SLL);
        clear_fwd();

        // sw $5,8($6) flushed
        drive_id(i_type(6'h2b, 5'd6, 5'd5, 16'h0008), 32'h200, 32'h55, 32'h8,
                 ALU_ADD, 1'b0, 1'b1, REGDST_RT, 1'b0, 1'b0, 1'b1, 1'b0);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("fl_memwrite", EX_MemWrite, 0);
        check("fl_regwrite", EX_RegWrite, 0);
        check("fl_in2", EX_In2, 32'h0);

        // Flush together with a load-use stall yields one bubble
        drive_lw8();
        tick();
        drive_id(r_type(5'd8, 5'd0, 5'd9, 5'd0), 32'h0, 32'h0, 32'h0,
                 ALU_ADD, 1'b0, 1'b0, REGDST_RD, 1'b1, 1'b0, 1'b0, 1'b0);
        Flush = 1'b1;
        #1;
        check("fs_stall", LoadUseStall, 1);
        tick();
        Flush = 1'b0;
        check("fs_bub_regwrite", EX_RegWrite, 0);
        check("fs_bub_memread", EX_MemRead, 0);
        drive_id(r_type(5'd13, 5'd14, 5'd12, 5'd0), 32'h13, 32'h14, 32'h0,
                 ALU_OR, 1'b0, 1'b0, REGDST_RD, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("fs_nostall", LoadUseStall, 0);
        tick();
        check("fs_or_regwrite", EX_RegWrite, 1);
        check("fs_or_waddr", EX_WriteAddr, 12);
        check("fs_or_in1", EX_In1, 32'h13);
        check("fs_or_alu", EX_ALUCtrl, ALU_OR);

        // jal: RegDst=2 selects r31; RegDst=3 maps to r0
        drive_id(32'h0C000000, 32'h0, 32'h0, 32'h0,
                 ALU_ADD, 1'b0, 1'b0, REGDST_RA, 1'b1, 1'b0, 1'b0, 1'b0);
        ID_PCPlus4 = 32'h00400008;
        tick();
        check("jal_waddr", EX_WriteAddr, 31);
        check("jal_pc4", EX_PCPlus4, 32'h00400008);
        drive_id(r_type(5'd1, 5'd2, 5'd3, 5'd0), 32'h0, 32'h0, 32'h0,
                 ALU_ADD, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("dst3_waddr", EX_WriteAddr, 0);

        // Reset in the middle of a load-use stall
        drive_lw8();
        tick();
        drive_id(r_type(5'd8, 5'd8, 5'd9, 5'd0), 32'h77, 32'h88, 32'h99,
                 ALU_ADD, 1'b0, 1'b0, REGDST_RD, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("rs_stall_pre", LoadUseStall, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rs_memread", EX_MemRead, 0);
        check("rs_regwrite", EX_RegWrite, 0);
        check("rs_waddr", EX_WriteAddr, 0);
        check("rs_in1", EX_In1, 32'h0);
        check("rs_pc4", EX_PCPlus4, 32'h0);
        check("rs_stall", LoadUseStall, 0);
        drive_id(r_type(5'd13, 5'd14, 5'd12, 5'd0), 32'h13, 32'h14, 32'h0,
                 ALU_SLT, 1'b0, 1'b0, REGDST_RD, 1'b1, 1'b0, 1'b0, 1'b0);
        ID_Sign = 1'b1;
        tick();
        check("resume_sign", EX_Sign, 1);
        check("resume_alu", EX_ALUCtrl, ALU_SLT);
        check("resume_in2", EX_In2, 32'h14);
        check("resume_pc4", EX_PCPlus4, 32'h00400008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
